// File: rtl/servo_pkg.sv
// Shared definitions for the servo clock-divider controller: reset ratio and
// the ratio-change FSM state encoding.
package servo_pkg;

  localparam int unsigned DEFAULT_DIV_C = 100;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    PEND
  } state_e;

endpackage

// File: rtl/div_core.sv
// Even-ratio divider core: 50 % duty clk_out with period div_i, a registered
// tick one cycle after each rising phase starts, and a synchronous phase load.
module div_core #(
  parameter int DIV_W = 32
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_i,
  input  logic             load_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             term_o
);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] tc;
  logic             clk_out_q, clk_out_d;
  logic             clk_prev_q;
  logic             tick_q;

  assign tc     = (div_i >> 1) - DIV_W'(1);
  assign term_o = (count_q == tc);

  // A load always lands on a terminate of the high phase, so forcing the phase
  // low here matches the natural falling edge and never creates a runt.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    count_d   = count_q + DIV_W'(1);
    clk_out_d = clk_out_q;
    if (load_i) begin
      count_d   = '0;
      clk_out_d = 1'b0;
    end else if (term_o) begin
      count_d   = '0;
      clk_out_d = ~clk_out_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      clk_out_q  <= 1'b0;
      clk_prev_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      clk_out_q  <= clk_out_d;
      clk_prev_q <= clk_out_q;
      tick_q     <= clk_out_q & ~clk_prev_q;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Servo clock-divider controller: round-robin arbitration of ratio requests,
// validation, and commit of accepted ratios on a full clk_out period boundary.
module clk_div_ctrl
  import servo_pkg::*;
#(
  parameter int          N_REQ       = 2,
  parameter int          DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DIV_W-1:0] req_div,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       err,
  output logic                   busy,
  output logic [DIV_W-1:0]       cur_div,
  output logic                   clk_out,
  output logic                   tick
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cur_div_q;
  logic [N_REQ-1:0] ack_q, err_q;
  logic             busy_q;

  logic [N_REQ-1:0] elig;
  logic             found;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] rr_ptr_d;
  logic [DIV_W-1:0] sel_div;
  logic             term;
  logic             boundary;
  logic             commit;

  // Requesters being acknowledged or rejected this cycle still hold req high.
  assign elig = req & ~ack_q & ~err_q;

  always_comb begin
    int idx;
    int nxt;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
    nxt = int'(pick) + 1;
    if (nxt >= N_REQ) nxt = 0;
    rr_ptr_d = IDX_W'(nxt);
    sel_div  = req_div[int'(pick)*DIV_W +: DIV_W];
  end

  assign boundary = term & clk_out;
  assign commit   = (state_q == PEND) & boundary;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      div_q     <= '0;
      cur_div_q <= DIV_W'(DEFAULT_DIV);
      ack_q     <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_q  <= pick;
            div_q    <= sel_div;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= CHECK;
            busy_q   <= 1'b1;
          end
        end
        CHECK: begin
          if (div_q < DIV_W'(2) || div_q[0]) begin
            err_q[grant_q] <= 1'b1;
            state_q        <= IDLE;
            busy_q         <= 1'b0;
          end else if (div_q == cur_div_q) begin
            ack_q[grant_q] <= 1'b1;
            state_q        <= IDLE;
            busy_q         <= 1'b0;
          end else begin
            state_q <= PEND;
          end
        end
        PEND: begin
          if (boundary) begin
            cur_div_q      <= div_q;
            ack_q[grant_q] <= 1'b1;
            state_q        <= IDLE;
            busy_q         <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  div_core #(
    .DIV_W(DIV_W)
  ) u_div_core (
    .clk_in   (clk_in),
    .rst      (rst),
    .div_i    (cur_div_q),
    .load_i   (commit),
    .clk_out_o(clk_out),
    .tick_o   (tick),
    .term_o   (term)
  );

  assign ack     = ack_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with DEFAULT_DIV=10 and two requesters.
module tb_clk_div_ctrl;

  localparam int N = 2;
  localparam int W = 32;

  logic           clk_in = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_div;
  logic [N-1:0]   ack, err;
  logic           busy;
  logic [W-1:0]   cur_div;
  logic           clk_out;
  logic           tick;

  clk_div_ctrl #(
    .N_REQ      (N),
    .DIV_W      (W),
    .DEFAULT_DIV(10)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .req    (req),
    .req_div(req_div),
    .ack    (ack),
    .err    (err),
    .busy   (busy),
    .cur_div(cur_div),
    .clk_out(clk_out),
    .tick   (tick)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic        busy;
    logic [31:0] cur;
  } vec_t;

  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic wait_rise(output bit ok, output int at);
    logic prev;
    prev = clk_out;
    ok   = 1'b0;
    at   = -1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!prev && clk_out) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
      prev = clk_out;
    end
  endtask

  // Leaves the bench on the sample where clk_out has just risen again.
  task automatic measure(input string nm, input int exp_hi, input int exp_lo);
    bit ok;
    int at, hi, lo;
    wait_rise(ok, at);
    check({nm, "_rise_seen"}, ok, 1);
    hi = 0;
    lo = 0;
    for (int i = 0; i < 100 && clk_out; i++) begin
      hi++;
      step();
    end
    for (int i = 0; i < 100 && !clk_out; i++) begin
      lo++;
      step();
    end
    check({nm, "_high"}, hi, exp_hi);
    check({nm, "_low"}, lo, exp_lo);
  endtask

  task automatic serve(input logic [1:0] mask, input logic [31:0] d0, input logic [31:0] d1,
                       input int first, input string nm);
    logic [1:0] pend;
    logic [1:0] err_seen;
    int         order0;
    pend     = mask;
    err_seen = '0;
    order0   = -1;
    req      = mask;
    req_div  = {d1, d0};
    for (int i = 0; i < 100 && pend != 0; i++) begin
      step();
      err_seen = err_seen | err;
      for (int j = 0; j < N; j++) begin
        if (pend[j] && ack[j]) begin
          if (order0 < 0) order0 = j;
          check({nm, "_cur_at_ack"}, cur_div, (j == 1) ? d1 : d0);
          pend[j] = 1'b0;
          req[j]  = 1'b0;
        end
      end
    end
    req = '0;
    check({nm, "_all_acked"}, pend, 0);
    check({nm, "_first"}, order0, first);
    check({nm, "_no_err"}, err_seen, 0);
  endtask

  initial begin
    bit         ok;
    int         r0, r1, lat, lo, hi, lo2;
    logic       prev;
    logic [1:0] ack_seen;

    vecs[0] = '{2'b10, 32'd0, 32'd7,  2'b00, 2'b00, 1'b1, 32'd10};
    vecs[1] = '{2'b10, 32'd0, 32'd7,  2'b00, 2'b10, 1'b0, 32'd10};
    vecs[2] = '{2'b00, 32'd0, 32'd0,  2'b00, 2'b00, 1'b0, 32'd10};
    vecs[3] = '{2'b10, 32'd0, 32'd0,  2'b00, 2'b00, 1'b1, 32'd10};
    vecs[4] = '{2'b10, 32'd0, 32'd0,  2'b00, 2'b10, 1'b0, 32'd10};
    vecs[5] = '{2'b00, 32'd0, 32'd0,  2'b00, 2'b00, 1'b0, 32'd10};
    vecs[6] = '{2'b10, 32'd0, 32'd10, 2'b00, 2'b00, 1'b1, 32'd10};
    vecs[7] = '{2'b10, 32'd0, 32'd10, 2'b10, 2'b00, 1'b0, 32'd10};
    vecs[8] = '{2'b00, 32'd0, 32'd0,  2'b00, 2'b00, 1'b0, 32'd10};

    rst     = 1'b1;
    req     = '0;
    req_div = '0;
    repeat (3) step();
    check("rst_clk_out", clk_out, 0);
    check("rst_cur_div", cur_div, 10);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", tick, 0);
    rst = 1'b0;

    measure("reset_period", 5, 5);
    check("tick_at_rise", tick, 0);
    step();
    check("tick_after_rise", tick, 1);
    step();
    check("tick_pulse_end", tick, 0);

    // Ratio 6 requested in the middle of a high phase.
    wait_rise(ok, r0);
    check("t6_rise_seen", ok, 1);
    step();
    step();
    req     = 2'b01;
    req_div = {32'd0, 32'd6};
    prev    = clk_out;
    lat     = -1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (ack[0]) begin
        lat = k;
        break;
      end
      prev = clk_out;
    end
    req = '0;
    check("t6_ack_seen", lat > 0, 1);
    check("t6_latency_bound", lat <= 12, 1);
    check("t6_high_before_ack", prev, 1);
    check("t6_fall_at_ack", clk_out, 0);
    check("t6_cur_div", cur_div, 6);
    lo = 0;
    hi = 0;
    lo2 = 0;
    for (int i = 0; i < 50 && !clk_out; i++) begin lo++; step(); end
    for (int i = 0; i < 50 && clk_out; i++) begin hi++; step(); end
    for (int i = 0; i < 50 && !clk_out; i++) begin lo2++; step(); end
    check("t6_first_low", lo, 3);
    check("t6_first_high", hi, 3);
    check("t6_second_low", lo2, 3);

    serve(2'b01, 32'd2, 32'd0, 0, "div2");
    measure("div2_period", 1, 1);
    serve(2'b10, 32'd0, 32'd10, 1, "restore10");

    // Rejections and an equal-ratio ack must leave the clk_out phase alone.
    wait_rise(ok, r0);
    check("tbl_rise_seen", ok, 1);
    for (int i = 0; i < 9; i++) begin
      req     = vecs[i].req;
      req_div = {vecs[i].d1, vecs[i].d0};
      step();
      check($sformatf("vec%0d_ack", i), ack, vecs[i].ack);
      check($sformatf("vec%0d_err", i), err, vecs[i].err);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d_cur_div", i), cur_div, vecs[i].cur);
    end
    wait_rise(ok, r1);
    check("tbl_rise_after", ok, 1);
    check("tbl_phase_kept", (r1 - r0) % 10, 0);
    measure("tbl_period", 5, 5);

    serve(2'b11, 32'd8, 32'd12, 0, "rr_a");
    check("rr_a_final", cur_div, 12);
    serve(2'b01, 32'd10, 32'd0, 0, "back10");
    serve(2'b11, 32'd8, 32'd12, 1, "rr_b");
    check("rr_b_final", cur_div, 8);

    // Reset in the middle of a pending change.
    wait_rise(ok, r0);
    check("pend_rise_seen", ok, 1);
    req     = 2'b01;
    req_div = {32'd0, 32'd6};
    step();
    step();
    check("pend_busy", busy, 1);
    check("pend_clk_high", clk_out, 1);
    check("pend_no_ack", ack, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cur_div", cur_div, 10);
    check("async_rst_clk_out", clk_out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ack", ack, 0);
    req = '0;
    step();
    step();
    rst = 1'b0;
    ack_seen = '0;
    for (int i = 0; i < 30; i++) begin
      step();
      ack_seen = ack_seen | ack;
    end
    check("post_rst_no_ack", ack_seen, 0);
    check("post_rst_cur_div", cur_div, 10);
    measure("post_rst_period", 5, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
